gpu_prim_assembler: RTL and testbench
=====================================

// Module: gpu_prim_assembler
// PURPOSE
//  Receives GPU commands from the execute stage output: BEGINPRIMITIVE, SETCOLOR, SETVERTEX, ENDPRIMITIVE.
//  Assembles them into complete point, line or triangle primitives.
//  Buffers the primitives in a small FIFO and hands them to the rasterizer on a valid/ready handshake.
//  Asserts O_Stall back to the pipeline when the FIFO is full.
// PARAMETERS
//  FIFO_DEPTH  4   primitive FIFO entries (power of 2, >=2)
//  PTR_W       2   log2(FIFO_DEPTH)
// PORTS
//  I_CLOCK       in   1    pipeline clock; all state updates on negedge, as in the pipeline stages
//  I_RESET_N     in   1    asynchronous, active-low reset
//  I_LOCK        in   1    upstream command valid
//  I_FetchStall  in   1    upstream bubble; command ignored when 1
//  I_DepStall    in   1    upstream bubble; command ignored when 1
//  I_Opcode      in   `OPCODE_WIDTH  command opcode (`OP_* from global_def.h)
//  I_DestValueV  in   `VREG_WIDTH (64)  vertex/colour; [15:0] x|r, [31:16] y|g, [47:32] z|b; [63:48] ignored
//  I_Type        in   4    primitive type for BEGINPRIMITIVE: 0 point, 1 line, 2 triangle, others invalid
//  O_Stall       out  1    FIFO full; upstream must hold its command
//  O_PrimValid   out  1    FIFO head valid
//  I_PrimReady   in   1    rasterizer accepts head
//  O_PrimType    out  4    head primitive type
//  O_PrimV0      out  48   vertex 0 {z,y,x}
//  O_PrimV1      out  48   vertex 1; 0 when unused
//  O_PrimV2      out  48   vertex 2; 0 when unused
//  O_PrimColor   out  48   flat colour {b,g,r}
//  O_ProtoErr    out  1    sticky protocol-error flag
//  O_PrimCount   out  16   count of primitives popped, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Accept condition: acc = I_LOCK & ~I_FetchStall & ~I_DepStall & ~O_Stall.
//  Opcodes other than the four listed are ignored.
//  Reset (I_RESET_N=0, asynchronous):
//   - state IDLE; vertex count 0; colour 0; FIFO empty
//   - all outputs 0, including O_ProtoErr and O_PrimCount
//   - an asserted reset mid-primitive discards any partial vertices
//  FSM states: IDLE (no open primitive), COLLECT (open primitive, type T, needs N=T+1 vertices, vcnt 0..N-1).
//  SETCOLOR (any state): colour <= I_DestValueV[47:0]. Takes effect for primitives pushed on later edges.
//  BEGINPRIMITIVE:
//   - valid type: -> COLLECT, T latched, vcnt <= 0
//   - invalid type: -> IDLE, ProtoErr <= 1
//   - while already in COLLECT: partial vertices are discarded, ProtoErr <= 1, then restart as above
//  SETVERTEX in IDLE: ignored, ProtoErr <= 1.
//  SETVERTEX in COLLECT:
//   - slot[vcnt] <= I_DestValueV[47:0]
//   - if vcnt == N-1: push {T, slot0, slot1, slot2, colour}, including the vertex written this edge
//   - unused slots are pushed as 0; vcnt <= 0; remain COLLECT (list mode, same T)
//   - otherwise vcnt <= vcnt + 1
//  ENDPRIMITIVE:
//   - COLLECT -> IDLE
//   - if vcnt != 0: partial primitive discarded, ProtoErr <= 1
//   - in IDLE: ProtoErr <= 1, no other effect
//  FIFO:
//   - O_PrimValid = count != 0
//   - head outputs are registered FIFO contents; pop when O_PrimValid & I_PrimReady
//   - push and pop on the same edge leave count unchanged; order is preserved; pointers wrap modulo FIFO_DEPTH
//  Stall and latency:
//   - O_Stall = (count == FIFO_DEPTH), decoded from registers
//   - no push can occur when full, because acc is 0
//   - a pop while full clears O_Stall from the next edge
//   - latency from the completing SETVERTEX edge to O_PrimValid=1 is 1 edge; primitive outputs hold while I_PrimReady=0
//  O_PrimCount increments on each pop.
// TESTING
//  1. Reset mid-COLLECT after 2 triangle vertices.
//     -> all outputs 0. A following SETVERTEX sets ProtoErr=1 (IDLE) and produces no push.
//  2. SETCOLOR 48'h0000_0080_00FF; BEGIN T=2; vertices (1,2,3), (4,5,6), (7,8,9); I_PrimReady=1.
//     -> one primitive: type 2, V0=48'h0003_0002_0001, V2=48'h0009_0008_0007, colour 48'h0000_0080_00FF.
//     -> O_PrimCount=1.
//  3. I_PrimReady=0; BEGIN T=0; 5 SETVERTEX (x=1..5).
//     -> O_Stall=1 after the 4th push; 5th command held.
//     -> on ready=1: heads x=1,2,3,4,5 in order; stall drops after the first pop.
//  4. BEGIN T=1; 1 vertex; END.
//     -> nothing pushed, ProtoErr=1, state IDLE.
//  5. SETVERTEX with I_DepStall=1, then with I_FetchStall=1, then with I_LOCK=0.
//     -> no state change, no push.
//  6. BEGIN T=4'hF.
//     -> ProtoErr=1; a following SETVERTEX pushes nothing.

Source files
------------

// File: rtl/gpu_prim_assembler.sv
// Assembles BEGIN/COLOR/VERTEX/END commands into point/line/triangle primitives and queues them
// for the rasterizer; one negedge from the completing vertex to O_PrimValid, O_Stall while the queue is full.
module gpu_prim_assembler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_W        = 2,
  parameter int OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'h80,
  parameter logic [OPCODE_WIDTH-1:0] OP_SETCOLOR       = 8'h81,
  parameter logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = 8'h82,
  parameter logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = 8'h83
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [63:0]             I_DestValueV,
  input  logic [3:0]              I_Type,
  output logic                    O_Stall,
  output logic                    O_PrimValid,
  input  logic                    I_PrimReady,
  output logic [3:0]              O_PrimType,
  output logic [47:0]             O_PrimV0,
  output logic [47:0]             O_PrimV1,
  output logic [47:0]             O_PrimV2,
  output logic [47:0]             O_PrimColor,
  output logic                    O_ProtoErr,
  output logic [15:0]             O_PrimCount
);

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  typedef struct packed {
    logic [3:0]  ptype;
    logic [47:0] v0;
    logic [47:0] v1;
    logic [47:0] v2;
    logic [47:0] color;
  } prim_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  state_t          state_q, state_d;
  logic [3:0]      type_q, type_d;
  logic [1:0]      vcnt_q, vcnt_d;
  logic [47:0]     color_q, color_d;
  logic [47:0]     slot0_q, slot0_d;
  logic [47:0]     slot1_q, slot1_d;
  logic            err_q, err_d;
  logic [15:0]     pcnt_q;
  logic [PTR_W:0]  count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  prim_t           mem_q [FIFO_DEPTH];

  logic            acc;
  logic            push;
  logic            pop;
  prim_t           push_dat;
  logic [47:0]     vtx;
  logic            unused_hi;

  assign unused_hi = ^I_DestValueV[63:48];
  assign vtx       = I_DestValueV[47:0];
  assign O_Stall   = (count_q == FULL_CNT);
  assign acc       = I_LOCK & ~I_FetchStall & ~I_DepStall & ~O_Stall;
  assign pop       = (count_q != '0) & I_PrimReady;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    vcnt_d   = vcnt_q;
    color_d  = color_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    err_d    = err_q;
    push     = 1'b0;
    push_dat = '0;
    if (acc) begin
      case (I_Opcode)
        OP_SETCOLOR: color_d = vtx;
        OP_BEGINPRIMITIVE: begin
          if (state_q == S_COLLECT) err_d = 1'b1;
          vcnt_d = 2'd0;
          if (I_Type <= 4'd2) begin
            state_d = S_COLLECT;
            type_d  = I_Type;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        OP_SETVERTEX: begin
          if (state_q == S_IDLE) begin
            err_d = 1'b1;
          end else if (vcnt_q == type_q[1:0]) begin
            // The completing vertex goes straight into the pushed entry, never into a slot.
            push           = 1'b1;
            vcnt_d         = 2'd0;
            push_dat.ptype = type_q;
            push_dat.color = color_q;
            case (type_q[1:0])
              2'd0: push_dat.v0 = vtx;
              2'd1: begin
                push_dat.v0 = slot0_q;
                push_dat.v1 = vtx;
              end
              default: begin
                push_dat.v0 = slot0_q;
                push_dat.v1 = slot1_q;
                push_dat.v2 = vtx;
              end
            endcase
          end else begin
            if (vcnt_q == 2'd0) slot0_d = vtx;
            else                slot1_d = vtx;
            vcnt_d = vcnt_q + 2'd1;
          end
        end
        OP_ENDPRIMITIVE: begin
          if (state_q == S_COLLECT) begin
            state_d = S_IDLE;
            vcnt_d  = 2'd0;
            if (vcnt_q != 2'd0) err_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      vcnt_q  <= '0;
      color_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      vcnt_q  <= vcnt_d;
      color_q <= color_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      err_q   <= err_d;
    end
  end

  // Storage is cleared on reset so the head outputs read 0 until the first push.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pcnt_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        pcnt_q   <= pcnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign O_PrimValid = (count_q != '0);
  assign O_PrimType  = mem_q[rd_ptr_q].ptype;
  assign O_PrimV0    = mem_q[rd_ptr_q].v0;
  assign O_PrimV1    = mem_q[rd_ptr_q].v1;
  assign O_PrimV2    = mem_q[rd_ptr_q].v2;
  assign O_PrimColor = mem_q[rd_ptr_q].color;
  assign O_ProtoErr  = err_q;
  assign O_PrimCount = pcnt_q;

endmodule

// File: tb/tb_gpu_prim_assembler.sv
// Directed bench for gpu_prim_assembler: commands applied between negedges, outputs checked 1ns after.
module tb_gpu_prim_assembler;

  localparam logic [7:0] OP_BEGIN = 8'h80;
  localparam logic [7:0] OP_COLOR = 8'h81;
  localparam logic [7:0] OP_VTX   = 8'h82;
  localparam logic [7:0] OP_END   = 8'h83;
  localparam logic [7:0] OP_NOP   = 8'h00;

  logic        I_CLOCK = 1'b1;
  logic        I_RESET_N = 1'b0;
  logic        I_LOCK = 1'b0;
  logic        I_FetchStall = 1'b0;
  logic        I_DepStall = 1'b0;
  logic [7:0]  I_Opcode = OP_NOP;
  logic [63:0] I_DestValueV = '0;
  logic [3:0]  I_Type = '0;
  logic        I_PrimReady = 1'b0;
  logic        O_Stall, O_PrimValid, O_ProtoErr;
  logic [3:0]  O_PrimType;
  logic [47:0] O_PrimV0, O_PrimV1, O_PrimV2, O_PrimColor;
  logic [15:0] O_PrimCount;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_prim_assembler dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall),
    .I_Opcode(I_Opcode), .I_DestValueV(I_DestValueV), .I_Type(I_Type),
    .O_Stall(O_Stall), .O_PrimValid(O_PrimValid), .I_PrimReady(I_PrimReady),
    .O_PrimType(O_PrimType), .O_PrimV0(O_PrimV0), .O_PrimV1(O_PrimV1),
    .O_PrimV2(O_PrimV2), .O_PrimColor(O_PrimColor), .O_ProtoErr(O_ProtoErr),
    .O_PrimCount(O_PrimCount)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [63:0] val, input logic [3:0] typ);
    I_LOCK = 1'b1;
    I_Opcode = op;
    I_DestValueV = val;
    I_Type = typ;
    @(negedge I_CLOCK);
    #1;
    I_LOCK = 1'b0;
    I_Opcode = OP_NOP;
  endtask

  task automatic idle();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic do_reset();
    I_RESET_N = 1'b0;
    #2;
    I_RESET_N = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"}, 64'(O_Stall), 64'd0);
    check({tag, " valid"}, 64'(O_PrimValid), 64'd0);
    check({tag, " type"}, 64'(O_PrimType), 64'd0);
    check({tag, " v0"}, 64'(O_PrimV0), 64'd0);
    check({tag, " v1"}, 64'(O_PrimV1), 64'd0);
    check({tag, " v2"}, 64'(O_PrimV2), 64'd0);
    check({tag, " color"}, 64'(O_PrimColor), 64'd0);
    check({tag, " err"}, 64'(O_ProtoErr), 64'd0);
    check({tag, " pcnt"}, 64'(O_PrimCount), 64'd0);
  endtask

  initial begin
    #2;
    check_all_zero("por");
    I_RESET_N = 1'b1;
    idle();

    // 1: reset mid-triangle
    issue(OP_BEGIN, 64'd0, 4'd2);
    issue(OP_VTX, 64'h0000_0003_0002_0001, 4'd0);
    issue(OP_VTX, 64'h0000_0006_0005_0004, 4'd0);
    check("t1 no push before reset", 64'(O_PrimValid), 64'd0);
    I_RESET_N = 1'b0;
    #1;
    check_all_zero("t1 reset");
    I_RESET_N = 1'b1;
    issue(OP_VTX, 64'h0000_0009_0008_0007, 4'd0);
    check("t1 err", 64'(O_ProtoErr), 64'd1);
    check("t1 no push", 64'(O_PrimValid), 64'd0);

    // 2: single triangle with colour
    do_reset();
    I_PrimReady = 1'b1;
    issue(OP_COLOR, 64'hFFFF_0000_0080_00FF, 4'd0);
    issue(OP_BEGIN, 64'd0, 4'd2);
    issue(OP_VTX, 64'h0000_0003_0002_0001, 4'd0);
    issue(OP_VTX, 64'h0000_0006_0005_0004, 4'd0);
    check("t2 not yet", 64'(O_PrimValid), 64'd0);
    issue(OP_VTX, 64'hABCD_0009_0008_0007, 4'd0);
    check("t2 valid", 64'(O_PrimValid), 64'd1);
    check("t2 type", 64'(O_PrimType), 64'd2);
    check("t2 v0", 64'(O_PrimV0), 64'h0003_0002_0001);
    check("t2 v1", 64'(O_PrimV1), 64'h0006_0005_0004);
    check("t2 v2", 64'(O_PrimV2), 64'h0009_0008_0007);
    check("t2 color", 64'(O_PrimColor), 64'h0000_0080_00FF);
    check("t2 pcnt before pop", 64'(O_PrimCount), 64'd0);
    idle();
    check("t2 popped", 64'(O_PrimValid), 64'd0);
    check("t2 pcnt", 64'(O_PrimCount), 64'd1);
    check("t2 err", 64'(O_ProtoErr), 64'd0);
    issue(OP_END, 64'd0, 4'd0);
    check("t2 clean end", 64'(O_ProtoErr), 64'd0);

    // 3: fill the FIFO with points, stall, then drain
    I_PrimReady = 1'b0;
    issue(OP_BEGIN, 64'd0, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      issue(OP_VTX, 64'(i), 4'd0);
      check($sformatf("t3 stall after push %0d", i), 64'(O_Stall), (i == 4) ? 64'd1 : 64'd0);
      check($sformatf("t3 head after push %0d", i), 64'(O_PrimV0), 64'd1);
    end
    check("t3 point v1", 64'(O_PrimV1), 64'd0);
    check("t3 point type", 64'(O_PrimType), 64'd0);
    I_LOCK = 1'b1;
    I_Opcode = OP_VTX;
    I_DestValueV = 64'd5;
    idle();
    check("t3 held stall", 64'(O_Stall), 64'd1);
    check("t3 held head", 64'(O_PrimV0), 64'd1);
    check("t3 held pcnt", 64'(O_PrimCount), 64'd1);
    I_PrimReady = 1'b1;
    idle();
    check("t3 stall drop", 64'(O_Stall), 64'd0);
    check("t3 head2", 64'(O_PrimV0), 64'd2);
    idle();
    I_LOCK = 1'b0;
    I_Opcode = OP_NOP;
    check("t3 head3", 64'(O_PrimV0), 64'd3);
    check("t3 stall after push5", 64'(O_Stall), 64'd0);
    idle();
    check("t3 head4", 64'(O_PrimV0), 64'd4);
    idle();
    check("t3 head5", 64'(O_PrimV0), 64'd5);
    check("t3 valid5", 64'(O_PrimValid), 64'd1);
    idle();
    check("t3 drained", 64'(O_PrimValid), 64'd0);
    check("t3 pcnt", 64'(O_PrimCount), 64'd6);
    check("t3 err", 64'(O_ProtoErr), 64'd0);

    // 4: truncated line
    issue(OP_END, 64'd0, 4'd0);
    check("t4 clean end", 64'(O_ProtoErr), 64'd0);
    issue(OP_BEGIN, 64'd0, 4'd1);
    issue(OP_VTX, 64'h0000_0000_0000_000A, 4'd0);
    issue(OP_END, 64'd0, 4'd0);
    check("t4 err", 64'(O_ProtoErr), 64'd1);
    check("t4 no push", 64'(O_PrimValid), 64'd0);
    issue(OP_VTX, 64'h0000_0000_0000_000B, 4'd0);
    check("t4 idle vtx no push", 64'(O_PrimValid), 64'd0);

    // 5: bubbles and unknown opcodes are ignored
    do_reset();
    check("t5 err cleared", 64'(O_ProtoErr), 64'd0);
    check("t5 pcnt cleared", 64'(O_PrimCount), 64'd0);
    issue(OP_BEGIN, 64'd0, 4'd0);
    I_DepStall = 1'b1;
    issue(OP_VTX, 64'd7, 4'd0);
    I_DepStall = 1'b0;
    check("t5 depstall", 64'(O_PrimValid), 64'd0);
    I_FetchStall = 1'b1;
    issue(OP_VTX, 64'd7, 4'd0);
    I_FetchStall = 1'b0;
    check("t5 fetchstall", 64'(O_PrimValid), 64'd0);
    I_Opcode = OP_VTX;
    I_DestValueV = 64'd7;
    idle();
    I_Opcode = OP_NOP;
    check("t5 nolock", 64'(O_PrimValid), 64'd0);
    issue(8'h55, 64'd7, 4'd0);
    check("t5 bad opcode", 64'(O_PrimValid), 64'd0);
    check("t5 err", 64'(O_ProtoErr), 64'd0);
    issue(OP_VTX, 64'd7, 4'd0);
    check("t5 real push", 64'(O_PrimValid), 64'd1);
    check("t5 v0", 64'(O_PrimV0), 64'd7);
    check("t5 color after reset", 64'(O_PrimColor), 64'd0);
    idle();
    check("t5 pcnt", 64'(O_PrimCount), 64'd1);

    // 6: invalid primitive type
    do_reset();
    issue(OP_BEGIN, 64'd0, 4'hF);
    check("t6 err", 64'(O_ProtoErr), 64'd1);
    issue(OP_VTX, 64'd9, 4'd0);
    check("t6 no push", 64'(O_PrimValid), 64'd0);
    check("t6 pcnt", 64'(O_PrimCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
